ecc_sed_decoder: RTL and testbench
==================================

// Module: ecc_sed_decoder
// PURPOSE
//  Receive side of the single-error-detect (SED) parity link. Checks each 13-bit codeword
//  {parity, data[11:0]} and forwards the data with a per-word error flag through a 2-entry
//  output buffer with valid/ready backpressure. Keeps a sticky error flag and an optional error counter.
//  Sits between the link/storage output and the consumer of decoded data.
// PARAMETERS
//  DATA_W    12  data bits per codeword; codeword width is DATA_W+1
//  ODD_PAR   0   0: even parity (^codeword==0 is clean); 1: odd parity (^codeword==1 is clean)
//  CNT_W     8   error-counter width, used only when ECC_SED_DEC_ERR_CNT_EN is defined
// PORTS
//  clk           in   1         clock, all state on rising edge
//  rst           in   1         reset, asynchronous, active-high
//  enc_valid     in   1         input codeword valid
//  enc_ready     out  1         decoder can accept a codeword
//  enc_codeword  in   DATA_W+1  {parity, data}, MSB is parity
//  dec_valid     out  1         decoded word valid
//  dec_ready     in   1         consumer accepts the decoded word
//  dec_data      out  DATA_W    decoded data = enc_codeword[DATA_W-1:0], passed through unmodified
//  dec_err       out  1         parity mismatch on this word, qualified by dec_valid
//  clr_err       in   1         synchronous clear for err_sticky and err_cnt
//  err_sticky    out  1         set by any accepted erroneous word, held until clr_err
//  err_cnt       out  CNT_W     saturating error count (present only with ECC_SED_DEC_ERR_CNT_EN)
// BEHAVIOUR
//  - Reset: buffer empty (count=0), dec_valid=0, dec_data=0, dec_err=0, err_sticky=0, err_cnt=0,
//    enc_ready=1. Asserting reset mid-transfer discards all buffered words.
//  - Accept: enc_valid && enc_ready at a clock edge. Syndrome = ^enc_codeword ^ ODD_PAR,
//    computed combinationally and stored with the data in the buffer.
//  - Buffer: 2-entry FIFO of {err, data}. enc_ready = (count != 2); depends on state only,
//    never on enc_valid or dec_ready. Head entry drives dec_data/dec_err; dec_valid = (count != 0).
//  - Latency: a word accepted at edge N appears on dec_* right after edge N when the buffer was empty.
//    Full throughput (one word per cycle) while dec_ready is held high.
//  - Pop: dec_valid && dec_ready. Simultaneous push and pop at count 1 keeps count at 1 and
//    order is preserved. At count 2 no push occurs. Pop at count 0 is impossible.
//  - Stable output: while dec_valid && !dec_ready, dec_data and dec_err hold unchanged.
//  - The error flag is attached to the word. It is never dropped and data is never corrected.
//  - err_sticky: set on accept of a word with syndrome 1. When clr_err and such an accept occur
//    in the same cycle, set wins (stays 1).
//  - Counter wrap: counter saturates at 2^CNT_W-1 and never wraps. clr_err with a simultaneous
//    error accept loads 1. clr_err alone loads 0.
// CONFIGURATION
//  - ECC_SED_DEC_ERR_CNT_EN defined: err_cnt port and counter logic are present.
//  - Not defined: err_cnt port and counter logic are absent; clr_err clears err_sticky only.
//    All other behaviour is identical.
// STRUCTURE
//  - Package ecc_sed_pkg: DATA_W_DEF=12, CW_W_DEF=13, PAR_POS=12, and a typedef of the
//    buffer entry struct {logic err; logic [DATA_W-1:0] data;}. The package is shared with the encoder.
//  - Sub-module ecc_sed_parity_chk: combinational, takes codeword and ODD_PAR, outputs syndrome.
//    The decoder holds the FIFO, handshake and error-statistics logic.
// TESTING
//  1. Clean word: 13'h0A5A with dec_ready=1 -> next cycle dec_valid=1, dec_data=12'hA5A, dec_err=0, err_sticky=0.
//  2. Single-bit error: 13'h1A5A, then 13'h0A5B -> both delivered in order with dec_err=1; err_sticky=1; err_cnt=2.
//  3. Backpressure: dec_ready=0, offer 13'h1001, 13'h0003, 13'h0005 -> enc_ready drops after 2 accepts;
//     the third word is held by the source; releasing dec_ready yields 001, 003, 005 with dec_err=0.
//  4. Clear race: clr_err=1 in the same cycle as accepting 13'h0001 -> err_sticky=1, err_cnt=1.
//  5. Saturation: CNT_W=2, 5 erroneous words -> err_cnt stops at 3.
//  6. Reset mid-stream: assert rst with 2 entries buffered -> dec_valid=0 at once, enc_ready=1, err_cnt=0.

Source files
------------

// File: rtl/ecc_sed_pkg.sv
// Shared definitions for the SED parity link (encoder and decoder).
// Widths, parity bit position and the buffered-entry layout.
package ecc_sed_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int CW_W_DEF   = 13;
  localparam int PAR_POS    = 12;

  typedef struct packed {
    logic                  err;
    logic [DATA_W_DEF-1:0] data;
  } sed_entry_t;

endpackage

// File: rtl/ecc_sed_parity_chk.sv
// Combinational parity checker for one codeword.
// syndrome=1 means the word failed the parity check.
module ecc_sed_parity_chk #(
  parameter int CW_W    = 13,
  parameter bit ODD_PAR = 1'b0
) (
  input  logic [CW_W-1:0] codeword,
  output logic            syndrome
);

  // Reduction XOR against the expected parity sense
  always_comb begin
    syndrome = (^codeword) ^ ODD_PAR;
  end

endmodule

// File: rtl/ecc_sed_decoder.sv
// SED decoder: parity check, 2-entry {err,data} output FIFO, sticky error flag.
// Define ECC_SED_DEC_ERR_CNT_EN to add the saturating err_cnt port and counter.
module ecc_sed_decoder
  import ecc_sed_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter bit ODD_PAR = 1'b0,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enc_valid,
  output logic              enc_ready,
  input  logic [DATA_W:0]   enc_codeword,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [DATA_W-1:0] dec_data,
  output logic              dec_err,
  input  logic              clr_err,
`ifdef ECC_SED_DEC_ERR_CNT_EN
  output logic [CNT_W-1:0]  err_cnt,
`endif
  output logic              err_sticky
);

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       syndrome;
  logic       push;
  logic       pop;
  logic       err_acc;

  ecc_sed_parity_chk #(
    .CW_W    (DATA_W + 1),
    .ODD_PAR (ODD_PAR)
  ) u_chk (
    .codeword (enc_codeword),
    .syndrome (syndrome)
  );

  // Handshake and head-of-queue outputs, all from registered state
  always_comb begin
    enc_ready = (count != 2'd2);
    dec_valid = (count != 2'd0);
    dec_data  = mem[rd_ptr].data;
    dec_err   = mem[rd_ptr].err;
    push      = enc_valid && enc_ready;
    pop       = dec_valid && dec_ready;
    err_acc   = push && syndrome;
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{err: syndrome, data: enc_codeword[DATA_W-1:0]};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error: a new error beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (err_acc) begin
      err_sticky <= 1'b1;
    end else if (clr_err) begin
      err_sticky <= 1'b0;
    end
  end

`ifdef ECC_SED_DEC_ERR_CNT_EN
  // Saturating error counter; clear with a new error restarts at one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_acc) begin
      if (clr_err) begin
        err_cnt <= CNT_W'(1);
      end else if (err_cnt != {CNT_W{1'b1}}) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end else if (clr_err) begin
      err_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_ecc_sed_decoder.sv
// Directed testbench for ecc_sed_decoder.
// Counter checks are compiled in when ECC_SED_DEC_ERR_CNT_EN is defined.
module tb_ecc_sed_decoder;

  localparam int DW = 12;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enc_valid;
  logic          enc_ready;
  logic [DW:0]   enc_codeword;
  logic          dec_valid;
  logic          dec_ready;
  logic [DW-1:0] dec_data;
  logic          dec_err;
  logic          clr_err;
  logic          err_sticky;
`ifdef ECC_SED_DEC_ERR_CNT_EN
  logic [CW-1:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ecc_sed_decoder #(
    .DATA_W  (DW),
    .ODD_PAR (1'b0),
    .CNT_W   (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enc_valid    (enc_valid),
    .enc_ready    (enc_ready),
    .enc_codeword (enc_codeword),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_data     (dec_data),
    .dec_err      (dec_err),
    .clr_err      (clr_err),
`ifdef ECC_SED_DEC_ERR_CNT_EN
    .err_cnt      (err_cnt),
`endif
    .err_sticky   (err_sticky)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic v,
                         input logic [DW-1:0] d, input logic e);
    checks++;
    if (dec_valid !== v || (v && (dec_data !== d || dec_err !== e))) begin
      errors++;
      $display("FAIL %s: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
               nm, dec_valid, dec_data, dec_err, v, d, e);
    end
  endtask

  task automatic chk_bit(input string nm, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, want %b", nm, got, want);
    end
  endtask

  task automatic chk_cnt(input string nm, input int want);
`ifdef ECC_SED_DEC_ERR_CNT_EN
    checks++;
    if (err_cnt !== CW'(want)) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, err_cnt, want);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enc_valid = 1'b0;
    enc_codeword = '0;
    dec_ready = 1'b0;
    clr_err = 1'b0;
    cyc();
    cyc();
    checks++;
    if (dec_valid !== 1'b0 || dec_data !== '0 || dec_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got v=%b d=%h e=%b, want 0 000 0",
               dec_valid, dec_data, dec_err);
    end
    chk_bit("reset_ready", enc_ready, 1'b1);
    chk_bit("reset_sticky", err_sticky, 1'b0);
    chk_cnt("reset_cnt", 0);
    #2 rst = 1'b0;
    cyc();
  endtask

  task automatic test_clean();
    dec_ready = 1'b1;
    enc_valid = 1'b1;
    enc_codeword = 13'h0A5A;
    cyc();
    enc_valid = 1'b0;
    chk_out("clean_word", 1'b1, 12'hA5A, 1'b0);
    chk_bit("clean_sticky", err_sticky, 1'b0);
    cyc();
    chk_out("clean_drained", 1'b0, '0, 1'b0);
  endtask

  task automatic test_single_err();
    enc_valid = 1'b1;
    enc_codeword = 13'h1A5A;
    cyc();
    chk_out("err_word0", 1'b1, 12'hA5A, 1'b1);
    enc_codeword = 13'h0A5B;
    cyc();
    enc_valid = 1'b0;
    chk_out("err_word1", 1'b1, 12'hA5B, 1'b1);
    cyc();
    chk_out("err_drained", 1'b0, '0, 1'b0);
    chk_bit("err_sticky", err_sticky, 1'b1);
    chk_cnt("err_cnt2", 2);
  endtask

  task automatic test_clr_alone();
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    chk_bit("clr_sticky", err_sticky, 1'b0);
    chk_cnt("clr_cnt", 0);
  endtask

  task automatic test_backpressure();
    dec_ready = 1'b0;
    enc_valid = 1'b1;
    enc_codeword = 13'h1001;
    chk_bit("bp_ready0", enc_ready, 1'b1);
    cyc();
    enc_codeword = 13'h0003;
    chk_bit("bp_ready1", enc_ready, 1'b1);
    cyc();
    chk_bit("bp_full", enc_ready, 1'b0);
    chk_out("bp_head", 1'b1, 12'h001, 1'b0);
    enc_codeword = 13'h0005;
    cyc();
    chk_bit("bp_still_full", enc_ready, 1'b0);
    chk_out("bp_hold", 1'b1, 12'h001, 1'b0);
    dec_ready = 1'b1;
    cyc();
    chk_out("bp_out1", 1'b1, 12'h003, 1'b0);
    chk_bit("bp_ready_again", enc_ready, 1'b1);
    cyc();
    enc_valid = 1'b0;
    chk_out("bp_out2", 1'b1, 12'h005, 1'b0);
    cyc();
    chk_out("bp_empty", 1'b0, '0, 1'b0);
    chk_bit("bp_sticky", err_sticky, 1'b0);
  endtask

  task automatic test_clear_race();
    clr_err = 1'b1;
    enc_valid = 1'b1;
    enc_codeword = 13'h0001;
    cyc();
    clr_err = 1'b0;
    enc_valid = 1'b0;
    chk_out("race_word", 1'b1, 12'h001, 1'b1);
    chk_bit("race_sticky", err_sticky, 1'b1);
    chk_cnt("race_cnt", 1);
    cyc();
  endtask

  task automatic test_saturation();
    test_clr_alone();
    enc_valid = 1'b1;
    enc_codeword = 13'h0001;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk_cnt($sformatf("sat_%0d", k), (k > 3) ? 3 : k);
    end
    enc_valid = 1'b0;
    cyc();
    chk_bit("sat_sticky", err_sticky, 1'b1);
  endtask

  task automatic test_reset_mid();
    dec_ready = 1'b0;
    enc_valid = 1'b1;
    enc_codeword = 13'h1234;
    cyc();
    enc_codeword = 13'h0777;
    cyc();
    enc_valid = 1'b0;
    chk_bit("mid_full", enc_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_out("mid_valid", 1'b0, '0, 1'b0);
    chk_bit("mid_ready", enc_ready, 1'b1);
    chk_bit("mid_sticky", err_sticky, 1'b0);
    chk_cnt("mid_cnt", 0);
    cyc();
    #2 rst = 1'b0;
    dec_ready = 1'b1;
    enc_valid = 1'b1;
    enc_codeword = 13'h0003;
    cyc();
    enc_valid = 1'b0;
    chk_out("mid_after", 1'b1, 12'h003, 1'b0);
    cyc();
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_err();
    test_clr_alone();
    test_backpressure();
    test_clear_race();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
